// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit and its ALU_Control neighbour:
// opcodes, ALU operation codes, datapath mux selects, FSM states and instruction classes.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [2:0] ALU_OP_R      = 3'b000;
    localparam logic [2:0] ALU_OP_I      = 3'b001;
    localparam logic [2:0] ALU_OP_LUI    = 3'b010;
    localparam logic [2:0] ALU_OP_BRANCH = 3'b011;
    localparam logic [2:0] ALU_OP_ADD    = 3'b100;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_PC4     = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM_ACCESS,
        S_WRITEBACK
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_JAL,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/multicycle_control_unit_opcode_class_decoder.sv
// Combinational opcode-to-instruction-class map; anything unrecognised is ILLEGAL.
module opcode_class_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OPC_R:   instr_class = CLS_R;
            OPC_I:   instr_class = CLS_I;
            OPC_LUI: instr_class = CLS_LUI;
            OPC_LW:  instr_class = CLS_LW;
            OPC_SW:  instr_class = CLS_SW;
            OPC_BEQ: instr_class = CLS_BEQ;
            OPC_JAL: instr_class = CLS_JAL;
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a multicycle RV32 subset datapath; the instruction class
// is latched in DECODE and steers every later state. dbg_state exposes the current state.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       PC_Write_o,
    output logic       IR_Write_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic       I_or_D_o,
    output logic [1:0] ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [2:0] ALU_Op_o,
    output logic       Reg_Write_o,
    output logic [1:0] Result_Src_o,
    output logic       Illegal_o,
    output state_t     dbg_state
);

    state_t       state;
    state_t       next_state;
    instr_class_t cls;
    instr_class_t dec_class;

    opcode_class_decoder u_decoder (
        .opcode      (opcode_i),
        .instr_class (dec_class)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cls   <= CLS_ILLEGAL;
        end else begin
            state <= next_state;
            if (state == S_DECODE) cls <= dec_class;
        end
    end

    // Memory handshake: a request (Mem_Read_o/Mem_Write_o) is held steady until the cycle
    // in which mem_ready_i is high; that cycle completes the access and the FSM moves on.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:      if (mem_ready_i) next_state = S_DECODE;
            S_DECODE:     next_state = (dec_class == CLS_ILLEGAL) ? S_FETCH : S_EXECUTE;
            S_EXECUTE: begin
                case (cls)
                    CLS_R, CLS_I, CLS_LUI: next_state = S_WRITEBACK;
                    CLS_LW, CLS_SW:        next_state = S_MEM_ACCESS;
                    default:               next_state = S_FETCH;
                endcase
            end
            S_MEM_ACCESS: if (mem_ready_i) next_state = (cls == CLS_LW) ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK:  next_state = S_FETCH;
            default:      next_state = S_FETCH;
        endcase
    end

    always_comb begin
        PC_Write_o   = 1'b0;
        IR_Write_o   = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        I_or_D_o     = 1'b0;
        ALU_Src_A_o  = SRC_A_PC;
        ALU_Src_B_o  = SRC_B_RS2;
        ALU_Op_o     = ALU_OP_R;
        Reg_Write_o  = 1'b0;
        Result_Src_o = RES_ALU_OUT;
        Illegal_o    = 1'b0;
        case (state)
            S_FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_A_o = SRC_A_PC;
                ALU_Src_B_o = SRC_B_FOUR;
                ALU_Op_o    = ALU_OP_ADD;
                IR_Write_o  = mem_ready_i;
                PC_Write_o  = mem_ready_i;
            end
            S_DECODE: begin
                // Precompute the branch/jump target so EXECUTE can load PC from ALUOut.
                ALU_Src_A_o = SRC_A_OLD_PC;
                ALU_Src_B_o = SRC_B_IMM;
                ALU_Op_o    = ALU_OP_ADD;
                Illegal_o   = (dec_class == CLS_ILLEGAL);
            end
            S_EXECUTE: begin
                case (cls)
                    CLS_R: begin
                        ALU_Src_A_o = SRC_A_RS1;
                        ALU_Src_B_o = SRC_B_RS2;
                        ALU_Op_o    = ALU_OP_R;
                    end
                    CLS_I: begin
                        ALU_Src_A_o = SRC_A_RS1;
                        ALU_Src_B_o = SRC_B_IMM;
                        ALU_Op_o    = ALU_OP_I;
                    end
                    CLS_LUI: begin
                        ALU_Src_A_o = SRC_A_ZERO;
                        ALU_Src_B_o = SRC_B_IMM;
                        ALU_Op_o    = ALU_OP_LUI;
                    end
                    CLS_LW, CLS_SW: begin
                        ALU_Src_A_o = SRC_A_RS1;
                        ALU_Src_B_o = SRC_B_IMM;
                        ALU_Op_o    = ALU_OP_ADD;
                    end
                    CLS_BEQ: begin
                        ALU_Src_A_o = SRC_A_RS1;
                        ALU_Src_B_o = SRC_B_RS2;
                        ALU_Op_o    = ALU_OP_BRANCH;
                        PC_Write_o  = zero_i;
                    end
                    CLS_JAL: begin
                        Reg_Write_o  = 1'b1;
                        Result_Src_o = RES_PC4;
                        PC_Write_o   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM_ACCESS: begin
                I_or_D_o    = 1'b1;
                Mem_Read_o  = (cls == CLS_LW);
                Mem_Write_o = (cls == CLS_SW);
            end
            S_WRITEBACK: begin
                Reg_Write_o  = 1'b1;
                Result_Src_o = (cls == CLS_LW) ? RES_MEM : RES_ALU_OUT;
            end
            default: ;
        endcase
        // Strobes stay quiet while reset is held so an abandoned instruction writes nothing.
        if (reset) begin
            PC_Write_o  = 1'b0;
            IR_Write_o  = 1'b0;
            Mem_Write_o = 1'b0;
            Reg_Write_o = 1'b0;
            Illegal_o   = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port opcode_i, input, 7, opcode field of the instruction register (bits 6:0).
REQ-004 SHALL have port mem_ready_i, input, 1, memory done/data-valid for the current access.
REQ-005 SHALL have port zero_i, input, 1, ALU zero flag, used by BEQ.
REQ-006 SHALL have ports PC_Write_o and IR_Write_o, output, 1 each, PC and IR load enables.
REQ-007 SHALL have ports Mem_Read_o and Mem_Write_o, output, 1 each, memory strobes.
REQ-008 SHALL have port I_or_D_o, output, 1: 0 = PC address, 1 = ALUOut address.
REQ-009 SHALL have port ALU_Src_A_o, output, 2: 00 PC, 01 rs1, 10 old PC, 11 zero.
REQ-010 SHALL have port ALU_Src_B_o, output, 2: 00 rs2, 01 immediate, 10 constant 4.
REQ-011 SHALL have port ALU_Op_o, output, 3: 000 R-type, 001 I-type, 010 LUI, 011 branch compare, 100 address/PC add; drives ALU_Control.
REQ-012 SHALL have ports Reg_Write_o (1, register-file write enable) and Result_Src_o (2: 00 ALUOut, 01 memory data, 10 old PC+4), outputs.
REQ-013 SHALL have port Illegal_o, output, 1, one-cycle pulse on an unsupported opcode.

Function
REQ-014 SHALL be a Moore FSM with states FETCH, DECODE, EXECUTE, MEM_ACCESS, WRITEBACK; all outputs decoded from state plus latched instruction class only, except PC_Write_o in EXECUTE for BEQ (uses zero_i).
REQ-015 SHALL latch the instruction class (R, I, LUI, LW, SW, BEQ, JAL, ILLEGAL) from opcode_i in DECODE; opcodes 0110011, 0010011, 0110111, 0000011, 0100011, 1100011, 1101111; others ILLEGAL.
REQ-016 FETCH: Mem_Read_o=1, I_or_D_o=0, Src_A=00, Src_B=10, ALU_Op=100; hold while mem_ready_i=0; when 1, pulse IR_Write_o and PC_Write_o for that cycle only, then go to DECODE.
REQ-017 DECODE: Src_A=10, Src_B=01, ALU_Op=100 (branch/jump target into ALUOut); ILLEGAL -> pulse Illegal_o, return to FETCH; else EXECUTE.
REQ-018 EXECUTE R: Src_A=01, Src_B=00, ALU_Op=000 -> WRITEBACK.
REQ-019 EXECUTE I: Src_A=01, Src_B=01, ALU_Op=001 -> WRITEBACK; LUI: Src_A=11, Src_B=01, ALU_Op=010 -> WRITEBACK.
REQ-020 EXECUTE LW/SW: Src_A=01, Src_B=01, ALU_Op=100 -> MEM_ACCESS.
REQ-021 EXECUTE BEQ: Src_A=01, Src_B=00, ALU_Op=011; PC_Write_o=zero_i (PC from ALUOut) -> FETCH.
REQ-022 EXECUTE JAL: Reg_Write_o=1, Result_Src=10, PC_Write_o=1 (PC from ALUOut) -> FETCH.
REQ-023 MEM_ACCESS: I_or_D_o=1; LW asserts Mem_Read_o, SW asserts Mem_Write_o; hold until mem_ready_i=1; then LW -> WRITEBACK, SW -> FETCH.
REQ-024 WRITEBACK: Reg_Write_o=1 for exactly one cycle; Result_Src=01 for LW, 00 otherwise -> FETCH.
REQ-025 Zero-wait latencies SHALL be: BEQ/JAL 3 cycles, R/I/LUI/SW 4, LW 5; each mem_ready_i=0 cycle adds one.
REQ-026 Mem_Read_o and Mem_Write_o SHALL never be asserted together; Reg_Write_o and Mem_Write_o never together.
REQ-027 Unused outputs in any state SHALL be 0.

Reset
REQ-028 While reset=1 at a clk edge, FSM SHALL enter FETCH and class register SHALL clear to ILLEGAL; the next cycle drives FETCH outputs.
REQ-029 Reset mid-instruction (any state, incl. memory wait) SHALL abandon it with no Reg_Write_o, PC_Write_o or Mem_Write_o in the following cycle.
REQ-030 Reset value of all strobes (PC_Write, IR_Write, Mem_Write, Reg_Write, Illegal) SHALL be 0.

Structure
REQ-031 Shared package SHALL hold opcode constants, ALU_Op encodings (shared with ALU_Control), Src_A/Src_B/Result_Src encodings and the state enumeration.
REQ-032 One sub-module, opcode_class_decoder (combinational opcode -> class), SHALL be instantiated; FSM and output decode stay in the top.

Verification
REQ-033 ADD (0110011), mem_ready_i=1 always -> FETCH,DECODE,EXECUTE(ALU_Op=000),WRITEBACK(Reg_Write=1), back in FETCH at cycle 4.
REQ-034 LW, FETCH wait 2 cycles, MEM wait 3 cycles -> 10 cycles total, Mem_Read held through waits, Result_Src=01 in WRITEBACK.
REQ-035 BEQ with zero_i=1 then zero_i=0 -> PC_Write_o=1 in first EXECUTE, 0 in second; no Reg_Write_o.
REQ-036 opcode 1111111 -> Illegal_o pulse in DECODE, FETCH next cycle, no write strobes.
REQ-037 SW with reset asserted in MEM_ACCESS during wait -> Mem_Write_o=0 next cycle, FSM in FETCH.
REQ-038 Random opcode stream, all cycles -> assertions of REQ-026 and one-cycle Reg_Write_o hold.
